// File: rtl/mips_multicycle_controller_pkg.sv
// Shared definitions for the multicycle MIPS controller.
// Package mips_ctrl_pkg: FSM state enum, opcode/funct codes, ALUOP codes,
// aluControl codes shared with the datapath ALU, and an opcode-support helper.
// Optional feature macro: CTRL_JUMP_EN (enables the j instruction).
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // True for opcodes the controller can sequence; everything else traps in DECODE.
    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI: return 1'b1;
`ifdef CTRL_JUMP_EN
            OP_J: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// Controller <-> datapath bundle.
// master: controller (drives control lines, reads op/funct/zero).
// slave : datapath (drives op/funct from the IR and the ALU zero flag).
interface mips_multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] aluControl;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal;

    modport master (
        input  op, funct, zero,
        output aluControl, alusrca, alusrcb, pcsrc, pcen, iord,
               memwrite, irwrite, regdst, memtoreg, regwrite, illegal
    );

    modport slave (
        output op, funct, zero,
        input  aluControl, alusrca, alusrcb, pcsrc, pcen, iord,
               memwrite, irwrite, regdst, memtoreg, regwrite, illegal
    );
endinterface

// File: rtl/mips_multicycle_controller_alu_decoder.sv
// mips_alu_decoder: combinational ALU decoder.
// Ports: aluop (add/sub/funct), funct (instr[5:0]) -> alu_control (3-bit ALU
// code), funct_illegal (unsupported funct while aluop selects funct decode).
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    // Unknown funct keeps the harmless add code.
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: Moore FSM sequencing a multicycle MIPS datapath.
// Ports: clk, reset (sync, active-high), bus (master modport of
// mips_multicycle_controller_if: op/funct/zero in, control lines out).
// Parameter FETCH_WAIT (0..15): extra FETCH cycles for slow instruction memory.
// Optional macro CTRL_JUMP_EN: adds the JUMP state for op 000010; otherwise
// that opcode is reported illegal.
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int FETCH_WAIT = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    mips_multicycle_controller_if.master  bus
);

    localparam logic [3:0] WAIT_LAST = FETCH_WAIT[3:0];

    state_t     state, state_next, ostate;
    logic [3:0] waitcnt;
    logic       fetch_done;
    aluop_t     aluop;
    logic [2:0] alu_control;
    logic       funct_bad;
    logic       pcwrite, branch;
    logic       irwrite_s, memwrite_s, regwrite_s, illegal_s;

    assign fetch_done = (waitcnt == WAIT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            waitcnt <= '0;
        end else begin
            state <= state_next;
            if (state == S_FETCH && !fetch_done)
                waitcnt <= waitcnt + 4'd1;
            else
                waitcnt <= '0;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:   state_next = fetch_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
`ifdef CTRL_JUMP_EN
                    OP_J:         state_next = S_JUMP;
`endif
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:  state_next = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_next = S_MEMWB;
            S_EXECUTE: state_next = funct_bad ? S_FETCH : S_ALUWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    // While reset is held the outputs look like FETCH regardless of the
    // current state, so a mid-instruction reset never leaks a write.
    assign ostate = reset ? S_FETCH : state;

    // Output decode
    always_comb begin
        aluop       = ALUOP_ADD;
        bus.alusrca = 1'b0;
        bus.alusrcb = 2'b00;
        bus.pcsrc   = 2'b00;
        bus.iord    = 1'b0;
        bus.regdst  = 1'b0;
        bus.memtoreg = 1'b0;
        pcwrite     = 1'b0;
        branch      = 1'b0;
        irwrite_s   = 1'b0;
        memwrite_s  = 1'b0;
        regwrite_s  = 1'b0;
        illegal_s   = 1'b0;
        case (ostate)
            S_FETCH: begin
                bus.alusrcb = 2'b01;
                irwrite_s   = fetch_done;
                pcwrite     = fetch_done;
            end
            S_DECODE: begin
                bus.alusrcb = 2'b11;
                illegal_s   = !op_supported(bus.op);
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_MEMRD:  bus.iord = 1'b1;
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                regwrite_s   = 1'b1;
            end
            S_MEMWR: begin
                bus.iord   = 1'b1;
                memwrite_s = 1'b1;
            end
            S_EXECUTE: begin
                bus.alusrca = 1'b1;
                aluop       = ALUOP_FUNCT;
                illegal_s   = funct_bad;
            end
            S_ALUWB: begin
                bus.regdst = 1'b1;
                regwrite_s = 1'b1;
            end
            S_BRANCH: begin
                bus.alusrca = 1'b1;
                aluop       = ALUOP_SUB;
                bus.pcsrc   = 2'b01;
                branch      = 1'b1;
            end
            S_ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_ADDIWB: regwrite_s = 1'b1;
`ifdef CTRL_JUMP_EN
            S_JUMP: begin
                bus.pcsrc = 2'b10;
                pcwrite   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign bus.pcen     = !reset && (pcwrite || (branch && bus.zero));
    assign bus.irwrite  = !reset && irwrite_s;
    assign bus.memwrite = !reset && memwrite_s;
    assign bus.regwrite = !reset && regwrite_s;
    assign bus.illegal  = !reset && illegal_s;
    assign bus.aluControl = alu_control;

    mips_alu_decoder u_alu_dec (
        .aluop         (aluop),
        .funct         (bus.funct),
        .alu_control   (alu_control),
        .funct_illegal (funct_bad)
    );

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Self-checking bench for mips_multicycle_controller.
// Two instances: FETCH_WAIT=0 and FETCH_WAIT=2, each with its own bus; the
// idle instance is held in reset. Expected outputs come from a per-instruction
// microsequence model plus a table of per-instruction totals.
module tb_mips_multicycle_controller;

`ifdef CTRL_JUMP_EN
    localparam bit JEN = 1'b1;
`else
    localparam bit JEN = 1'b0;
`endif

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
    localparam logic [2:0] A_ADD = 3'b010;

    typedef struct packed {
        logic [2:0] alu;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, illegal;
    } ctrl_t;

    typedef struct {
        ctrl_t v;
        bit    c_alu, c_pc, c_iord, c_reg, pz;
    } exp_t;

    typedef struct packed {
        logic [5:0] op, funct;
        logic       zero;
        logic [3:0] cpi;
        logic [1:0] nreg, nmem, nill, npc;
    } row_t;

    logic       clk = 1'b0;
    logic       reset_d [2];
    logic [5:0] op_d [2];
    logic [5:0] funct_d [2];
    logic       zero_d [2];
    ctrl_t      out_d [2];
    exp_t       eq[$];
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    mips_multicycle_controller_if bus0 ();
    mips_multicycle_controller_if bus2 ();

    assign bus0.op = op_d[0];  assign bus0.funct = funct_d[0];  assign bus0.zero = zero_d[0];
    assign bus2.op = op_d[1];  assign bus2.funct = funct_d[1];  assign bus2.zero = zero_d[1];
    assign out_d[0] = {bus0.aluControl, bus0.alusrca, bus0.alusrcb, bus0.pcsrc, bus0.pcen,
                       bus0.iord, bus0.memwrite, bus0.irwrite, bus0.regdst, bus0.memtoreg,
                       bus0.regwrite, bus0.illegal};
    assign out_d[1] = {bus2.aluControl, bus2.alusrca, bus2.alusrcb, bus2.pcsrc, bus2.pcen,
                       bus2.iord, bus2.memwrite, bus2.irwrite, bus2.regdst, bus2.memtoreg,
                       bus2.regwrite, bus2.illegal};

    mips_multicycle_controller #(.FETCH_WAIT(0)) dut0 (.clk(clk), .reset(reset_d[0]), .bus(bus0));
    mips_multicycle_controller #(.FETCH_WAIT(2)) dut2 (.clk(clk), .reset(reset_d[1]), .bus(bus2));

    function automatic exp_t blank();
        exp_t e;
        e.v = '0; e.c_alu = 0; e.c_pc = 0; e.c_iord = 0; e.c_reg = 0; e.pz = 0;
        return e;
    endfunction

    function automatic exp_t alu_step(input logic a, input logic [1:0] b, input logic [2:0] c);
        exp_t e;
        e = blank(); e.c_alu = 1; e.v.srca = a; e.v.srcb = b; e.v.alu = c;
        return e;
    endfunction

    // Outputs expected while reset is held: FETCH selects, every enable off.
    function automatic exp_t reset_exp();
        exp_t e;
        e = alu_step(1'b0, 2'b01, A_ADD); e.c_pc = 1; e.c_iord = 1;
        return e;
    endfunction

    // Cycle-by-cycle expected outputs of one instruction, FETCH through writeback.
    function automatic void build(input int w, input logic [5:0] op, input logic [5:0] fn);
        exp_t e;
        logic [2:0] fa;
        bit fok;
        eq.delete();
        for (int i = 0; i <= w; i++) begin
            e = reset_exp();
            e.v.irwrite = (i == w); e.v.pcen = (i == w);
            eq.push_back(e);
        end
        e = alu_step(1'b0, 2'b11, A_ADD);
        e.v.illegal = !((op inside {LW, SW, RT, BEQ, ADDI}) || (JEN && op == JMP));
        eq.push_back(e);
        fok = 1; fa = A_ADD;
        case (fn)
            6'b100000: fa = 3'b010;
            6'b100010: fa = 3'b110;
            6'b100100: fa = 3'b000;
            6'b100101: fa = 3'b001;
            6'b101010: fa = 3'b111;
            default:   fok = 0;
        endcase
        case (op)
            LW: begin
                eq.push_back(alu_step(1'b1, 2'b10, A_ADD));
                e = blank(); e.c_iord = 1; e.v.iord = 1; eq.push_back(e);
                e = blank(); e.c_reg = 1; e.v.memtoreg = 1; e.v.regwrite = 1; eq.push_back(e);
            end
            SW: begin
                eq.push_back(alu_step(1'b1, 2'b10, A_ADD));
                e = blank(); e.c_iord = 1; e.v.iord = 1; e.v.memwrite = 1; eq.push_back(e);
            end
            RT: begin
                e = alu_step(1'b1, 2'b00, fa); e.v.illegal = !fok; eq.push_back(e);
                if (fok) begin
                    e = blank(); e.c_reg = 1; e.v.regdst = 1; e.v.regwrite = 1; eq.push_back(e);
                end
            end
            BEQ: begin
                e = alu_step(1'b1, 2'b00, 3'b110); e.c_pc = 1; e.v.pcsrc = 2'b01; e.pz = 1;
                eq.push_back(e);
            end
            ADDI: begin
                eq.push_back(alu_step(1'b1, 2'b10, A_ADD));
                e = blank(); e.c_reg = 1; e.v.regwrite = 1; eq.push_back(e);
            end
            JMP: if (JEN) begin
                e = blank(); e.c_pc = 1; e.v.pcsrc = 2'b10; e.v.pcen = 1; eq.push_back(e);
            end
            default: ;
        endcase
    endfunction

    task automatic cmp(input int d, input string nm, input exp_t e);
        ctrl_t a, x;
        bit bad;
        a = out_d[d]; x = e.v;
        if (e.pz) x.pcen = zero_d[d];
        bad = (a.pcen !== x.pcen) || (a.memwrite !== x.memwrite) || (a.irwrite !== x.irwrite) ||
              (a.regwrite !== x.regwrite) || (a.illegal !== x.illegal);
        if (e.c_alu && (a.alu !== x.alu || a.srca !== x.srca || a.srcb !== x.srcb)) bad = 1;
        if (e.c_pc && a.pcsrc !== x.pcsrc) bad = 1;
        if (e.c_iord && a.iord !== x.iord) bad = 1;
        if (e.c_reg && (a.regdst !== x.regdst || a.memtoreg !== x.memtoreg)) bad = 1;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s dut%0d t=%0t got=%b want=%b", nm, d, $time, a, x);
        end
    endtask

    // Runs one instruction from FETCH cycle 0 (called just after a negedge);
    // n > 0 stops after the first n cycles.
    task automatic run(input int d, input string nm, input logic [5:0] op,
                       input logic [5:0] fn, input int n);
        int lim;
        build((d == 0) ? 0 : 2, op, fn);
        lim = (n > 0) ? n : eq.size();
        op_d[d] = op; funct_d[d] = fn;
        for (int i = 0; i < lim; i++) begin
            zero_d[d] = 1'($urandom_range(0, 1));
            #1;
            cmp(d, nm, eq[i]);
            @(negedge clk);
        end
    endtask

    function automatic logic [5:0] pick_op(input int k);
        case (k)
            0: return LW;   1: return SW;   2: return RT;
            3: return BEQ;  4: return ADDI; 5: return JMP;
            default: return 6'($urandom);
        endcase
    endfunction

    function automatic logic [5:0] pick_fn(input int k);
        case (k)
            0: return 6'b100000; 1: return 6'b100010; 2: return 6'b100100;
            3: return 6'b100101; 4: return 6'b101010;
            default: return 6'($urandom);
        endcase
    endfunction

    row_t tbl [10];

    initial begin
        int   n, nreg, nmem, nill, npc;
        bit   done;
        row_t got, want;

        // op, funct, zero, cpi, #regwrite, #memwrite, #illegal, #pcen outside fetch
        tbl[0] = {LW,   6'd0,      1'b0, 4'd5, 2'd1, 2'd0, 2'd0, 2'd0};
        tbl[1] = {SW,   6'd0,      1'b0, 4'd4, 2'd0, 2'd1, 2'd0, 2'd0};
        tbl[2] = {RT,   6'b100000, 1'b0, 4'd4, 2'd1, 2'd0, 2'd0, 2'd0};
        tbl[3] = {RT,   6'b101010, 1'b1, 4'd4, 2'd1, 2'd0, 2'd0, 2'd0};
        tbl[4] = {RT,   6'b000111, 1'b0, 4'd3, 2'd0, 2'd0, 2'd1, 2'd0};
        tbl[5] = {ADDI, 6'd0,      1'b0, 4'd4, 2'd1, 2'd0, 2'd0, 2'd0};
        tbl[6] = {BEQ,  6'd0,      1'b1, 4'd3, 2'd0, 2'd0, 2'd0, 2'd1};
        tbl[7] = {BEQ,  6'd0,      1'b0, 4'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        if (JEN) tbl[8] = {JMP, 6'd0, 1'b0, 4'd3, 2'd0, 2'd0, 2'd0, 2'd1};
        else     tbl[8] = {JMP, 6'd0, 1'b0, 4'd2, 2'd0, 2'd0, 2'd1, 2'd0};
        tbl[9] = {6'b111111, 6'd0, 1'b0, 4'd2, 2'd0, 2'd0, 2'd1, 2'd0};

        reset_d[0] = 1'b1; reset_d[1] = 1'b1;
        op_d[0] = LW; op_d[1] = SW; funct_d[0] = '0; funct_d[1] = '0;
        zero_d[0] = 1'b0; zero_d[1] = 1'b0;

        // Held reset: enables stay low even with a lw opcode present.
        for (int i = 0; i < 3; i++) begin
            #1; cmp(0, "reset_hold", reset_exp());
            @(negedge clk);
        end
        reset_d[0] = 1'b0;
        run(0, "lw_w0", LW, 6'd0, 0);

        // Per-instruction totals, counted from one irwrite to the next.
        for (int r = 0; r < 10; r++) begin
            op_d[0] = tbl[r].op; funct_d[0] = tbl[r].funct; zero_d[0] = tbl[r].zero;
            n = 0; nreg = 0; nmem = 0; nill = 0; npc = 0; done = 0;
            while (!done && n < 20) begin
                #1;
                if (n > 0 && out_d[0].irwrite) done = 1;
                else begin
                    nreg += int'(out_d[0].regwrite);
                    nmem += int'(out_d[0].memwrite);
                    nill += int'(out_d[0].illegal);
                    if (!out_d[0].irwrite) npc += int'(out_d[0].pcen);
                    n++;
                    @(negedge clk);
                end
            end
            want = tbl[r];
            got  = {tbl[r].op, tbl[r].funct, tbl[r].zero, 4'(n), 2'(nreg), 2'(nmem), 2'(nill), 2'(npc)};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL table_row%0d got cpi/reg/mem/ill/pc=%0d/%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d/%0d",
                         r, n, nreg, nmem, nill, npc, tbl[r].cpi, tbl[r].nreg, tbl[r].nmem,
                         tbl[r].nill, tbl[r].npc);
            end
        end
        @(negedge clk);
        reset_d[0] = 1'b1;
        @(negedge clk);
        reset_d[0] = 1'b0;
        for (int i = 0; i < 40; i++)
            run(0, "rand_w0", pick_op($urandom_range(0, 6)), pick_fn($urandom_range(0, 6)), 0);
        reset_d[0] = 1'b1;

        // FETCH_WAIT=2 instance
        @(negedge clk);
        reset_d[1] = 1'b0;
        run(1, "sw_w2", SW, 6'd0, 0);

        // Reset asserted during MEMADR of a sw: no memwrite, restart in FETCH.
        build(2, SW, 6'd0);
        op_d[1] = SW;
        for (int i = 0; i < 5; i++) begin
            zero_d[1] = 1'($urandom_range(0, 1));
            #1; cmp(1, "sw_pre_reset", eq[i]);
            if (i == 4) reset_d[1] = 1'b1;
            @(negedge clk);
        end
        #1; cmp(1, "reset_in_memadr", reset_exp());
        @(negedge clk);
        reset_d[1] = 1'b0;
        run(1, "lw_after_reset", LW, 6'd0, 0);
        run(1, "jmp_w2", JMP, 6'd0, 0);
        for (int i = 0; i < 40; i++)
            run(1, "rand_w2", pick_op($urandom_range(0, 6)), pick_fn($urandom_range(0, 6)), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
